xge_pkt_tx_gen: RTL and testbench
=================================

// Module: xge_pkt_tx_gen
// PURPOSE
//  Synthesizable packet source that drives the XGE MAC packet-transmit interface (pkt_tx_*).
//  Emits a programmed number of frames of programmed length with a deterministic byte pattern.
//  Honours pkt_tx_full backpressure. Sits directly upstream of the MAC TX FIFO in the 156.25 MHz domain.
// PARAMETERS
//  LEN_W    14    width of the pkt_len input, in bytes
//  MAX_LEN  9600  maximum frame length in bytes; longer requests are clamped to it
//  IFG_CYC  2     idle cycles inserted between consecutive frames (0 = back-to-back)
//  CNT_W    16    width of the num_pkts input and of pkts_sent
// PORTS
//  clk_156m25      in   1      core clock
//  reset_156m25_n  in   1      asynchronous active-low reset
//  start           in   1      1-cycle pulse; begins a run when the FSM is in IDLE
//  abort           in   1      stop the run at the next frame boundary
//  num_pkts        in   CNT_W  frames in this run; 0 = run continuously until abort
//  pkt_len         in   LEN_W  frame length in bytes; sampled at start
//  seed            in   8      pattern seed; sampled at start
//  pkt_tx_full     in   1      MAC TX FIFO full
//  pkt_tx_data     out  64     frame data; byte 0 in bits [63:56]
//  pkt_tx_val      out  1      data valid
//  pkt_tx_sop      out  1      first word of frame
//  pkt_tx_eop      out  1      last word of frame
//  pkt_tx_mod      out  3      valid bytes in the eop word; 0 = 8 bytes; 0 on all non-eop words
//  busy            out  1      FSM is not in IDLE
//  done            out  1      1-cycle pulse when a run ends (normal completion or abort)
//  pkts_sent       out  CNT_W  frames fully emitted in the current run; wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: every output is 0; FSM goes to IDLE.
//   Reset asserted mid-frame truncates that frame; no eop is emitted.
//  All pkt_tx_* outputs are registered.
//  Word issue:
//   - A word is issued in cycle n+1 only if pkt_tx_full sampled 0 at edge n.
//   - If full sampled 1, that cycle has val=0. The same word is retried next cycle, with identical data/sop/eop/mod.
//   - sop, eop, mod and data are qualified by val. When val=0 they hold 0.
//  Length:
//   - L = pkt_len clamped to the range [1, MAX_LEN].
//   - Word count W = ceil(L/8); eop word mod = L[2:0].
//   - L <= 8 gives a single word with sop=eop=1.
//  Pattern: byte k of frame p (p counts from 0 in the run) = (seed + p + k) mod 256.
//  FSM states: IDLE, SEND, GAP.
//   - IDLE: start=1 latches num_pkts, L and seed; clears pkts_sent; -> SEND. start in any other state is ignored.
//   - SEND: issues words as above. When the eop word is issued, pkts_sent increments.
//     - Then, if the run is complete (pkts_sent+1 == num_pkts, num_pkts != 0) or abort is pending: -> IDLE, done=1 in the cycle after eop.
//     - Otherwise: -> GAP if IFG_CYC > 0, else -> SEND with sop on the next word.
//   - GAP: holds IFG_CYC cycles with val=0, then -> SEND.
//     - abort pending in GAP: -> IDLE with done=1.
//  abort: latched as pending in any non-IDLE state. It never truncates a frame. It is cleared on entry to IDLE.
//  abort together with start in IDLE: start wins; abort is ignored.
//  Latency: with full=0, the sop word appears 2 cycles after the start pulse.
// STRUCTURE
//  Shared package xge_pkg:
//   - tx_gen_state_e enum {IDLE, SEND, GAP}.
//   - Function xge_len2words(len) returning W and mod.
//   - Constant XGE_MAX_FRAME = 9600.
//  One sub-module: xge_pattern_word. Combinational; produces a 64-bit word from (seed+p, byte_offset).
//  The FSM, counters and output registers live in this module.
// TESTING
//  1. num_pkts=1, pkt_len=64, seed=0x10, full=0
//     -> 8 words; sop on word 0; eop+mod=0 on word 7; first word 0x1011121314151617; done 1 cycle after eop.
//  2. pkt_len=61 -> 8 words, eop word mod=5.
//     pkt_len=0 -> 1 word, sop=eop=1, mod=1.
//     pkt_len=20000 -> clamped to 9600 (1200 words, mod=0).
//  3. full held high for 5 cycles at word 3 of a 64-byte frame
//     -> val=0 for exactly those cycles; word 3 is re-presented unchanged; no word lost or duplicated.
//  4. num_pkts=3, IFG_CYC=2 -> exactly 2 idle cycles between frames.
//     Frame 1 byte 0 = seed+1. pkts_sent=3 at done.
//  5. num_pkts=0 continuous; abort raised mid-frame 4
//     -> frame 4 completes with eop; done pulses; no frame 5; busy falls.
//  6. Reset asserted mid-frame -> all outputs 0 asynchronously.
//     After release, the next start produces a clean sop frame.

Source files
------------

// File: rtl/xge_pkg.sv
// rtl/xge_pkg.sv - shared types and helpers for the XGE packet transmit generator
package xge_pkg;

  localparam int XGE_MAX_FRAME = 9600;
  localparam int XGE_LEN_W     = 14;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_gen_state_e;

  typedef struct packed {
    logic [XGE_LEN_W-1:0] words;
    logic [2:0]           mod;
  } xge_wlen_t;

  // Word count rounds up; mod is the byte count of the eop word, 0 meaning all 8.
  function automatic xge_wlen_t xge_len2words(input logic [XGE_LEN_W-1:0] len);
    xge_wlen_t r;
    r.words = (len >> 3) + {{(XGE_LEN_W-1){1'b0}}, |len[2:0]};
    r.mod   = len[2:0];
    return r;
  endfunction

endpackage

// File: rtl/xge_pattern_word.sv
// rtl/xge_pattern_word.sv - 64-bit pattern word, byte j = base + byte_off + j, byte 0 in [63:56]
module xge_pattern_word (
  input  logic [7:0]  base,
  input  logic [7:0]  byte_off,
  output logic [63:0] word
);

  always_comb begin
    word = '0;
    for (int j = 0; j < 8; j++) begin
      word[63-8*j -: 8] = base + byte_off + 8'(j);
    end
  end

endmodule

// File: rtl/xge_pkt_tx_gen.sv
// rtl/xge_pkt_tx_gen.sv - packet source driving the XGE MAC pkt_tx interface
module xge_pkt_tx_gen
  import xge_pkg::*;
#(
  parameter int LEN_W   = 14,
  parameter int MAX_LEN = XGE_MAX_FRAME,
  parameter int IFG_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_pkts,
  input  logic [LEN_W-1:0] pkt_len,
  input  logic [7:0]       seed,
  input  logic             pkt_tx_full,
  output logic [63:0]      pkt_tx_data,
  output logic             pkt_tx_val,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pkts_sent
);

  localparam logic [15:0] GAP_LAST = 16'(IFG_CYC - 1);

  tx_gen_state_e        state;
  logic [CNT_W-1:0]     num_q;
  logic [XGE_LEN_W-1:0] words_q;
  logic [XGE_LEN_W-1:0] word_idx;
  logic [XGE_LEN_W-1:0] len_c;
  logic [2:0]           mod_q;
  logic [7:0]           frame_base;
  logic [15:0]          gap_cnt;
  logic                 abort_pend;
  logic                 done_arm;
  logic [63:0]          pat_word;
  xge_wlen_t            wl;
  logic                 last_word;
  logic                 stop_req;

  always_comb begin
    if (pkt_len == '0)
      len_c = XGE_LEN_W'(1);
    else if (pkt_len > LEN_W'(MAX_LEN))
      len_c = XGE_LEN_W'(MAX_LEN);
    else
      len_c = XGE_LEN_W'(pkt_len);
  end

  assign wl        = xge_len2words(len_c);
  assign last_word = (word_idx == words_q - XGE_LEN_W'(1));
  assign stop_req  = ((num_q != '0) && (pkts_sent + CNT_W'(1) == num_q)) || abort_pend || abort;
  assign busy      = (state != IDLE);

  xge_pattern_word u_pattern (
    .base     (frame_base),
    .byte_off ({word_idx[4:0], 3'b000}),
    .word     (pat_word)
  );

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state       <= IDLE;
      num_q       <= '0;
      words_q     <= '0;
      word_idx    <= '0;
      mod_q       <= '0;
      frame_base  <= '0;
      gap_cnt     <= '0;
      abort_pend  <= 1'b0;
      done_arm    <= 1'b0;
      done        <= 1'b0;
      pkts_sent   <= '0;
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
    end else begin
      pkt_tx_data <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      // done trails the eop word by one cycle so it lines up after the last word is visible
      done        <= done_arm;
      done_arm    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_q      <= num_pkts;
            words_q    <= wl.words;
            mod_q      <= wl.mod;
            frame_base <= seed;
            word_idx   <= '0;
            pkts_sent  <= '0;
            abort_pend <= 1'b0;
            state      <= SEND;
          end
        end
        SEND: begin
          abort_pend <= abort_pend | abort;
          if (!pkt_tx_full) begin
            pkt_tx_val  <= 1'b1;
            pkt_tx_data <= pat_word;
            pkt_tx_sop  <= (word_idx == '0);
            if (last_word) begin
              pkt_tx_eop <= 1'b1;
              pkt_tx_mod <= mod_q;
              pkts_sent  <= pkts_sent + CNT_W'(1);
              word_idx   <= '0;
              frame_base <= frame_base + 8'd1;
              if (stop_req) begin
                state      <= IDLE;
                done_arm   <= 1'b1;
                abort_pend <= 1'b0;
              end else if (IFG_CYC > 0) begin
                state   <= GAP;
                gap_cnt <= '0;
              end
            end else begin
              word_idx <= word_idx + XGE_LEN_W'(1);
            end
          end
        end
        GAP: begin
          if (abort_pend || abort) begin
            state      <= IDLE;
            done       <= 1'b1;
            abort_pend <= 1'b0;
          end else if (gap_cnt == GAP_LAST) begin
            state <= SEND;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xge_pkt_tx_gen.sv
// tb/tb_xge_pkt_tx_gen.sv - self-checking bench for xge_pkt_tx_gen
module tb_xge_pkt_tx_gen;

  logic        clk_156m25 = 1'b0;
  logic        reset_156m25_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] num_pkts = '0;
  logic [15:0] pkt_len = '0;
  logic [7:0]  seed = '0;
  logic        pkt_tx_full = 1'b0;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop, busy, done;
  logic [2:0]  pkt_tx_mod;
  logic [15:0] pkts_sent;

  always #5 clk_156m25 = ~clk_156m25;

  xge_pkt_tx_gen #(.LEN_W(16)) dut (
    .clk_156m25(clk_156m25), .reset_156m25_n(reset_156m25_n), .start(start), .abort(abort),
    .num_pkts(num_pkts), .pkt_len(pkt_len), .seed(seed), .pkt_tx_full(pkt_tx_full),
    .pkt_tx_data(pkt_tx_data), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop),
    .pkt_tx_eop(pkt_tx_eop), .pkt_tx_mod(pkt_tx_mod), .busy(busy), .done(done),
    .pkts_sent(pkts_sent)
  );

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0, errors = 0;
  int          cyc = 0, start_cyc = 0;
  bit          chk_en = 1'b0;
  logic        full_prev = 1'b0;
  int          word_cnt, sop_cnt, eop_cnt, stall_cnt, done_cnt;
  int          first_sop_cyc, last_eop_cyc, done_cyc, pkts_at_done;
  bit          in_frame;
  logic [2:0]  last_mod;
  logic [63:0] sop_data[$];
  int          gaps[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word stream straight from the frame rules: clamp, round up, byte k = seed+p+k.
  task automatic push_run(input int n, input int len, input int sd);
    int   L, W;
    exp_t x;
    L = (len == 0) ? 1 : (len > 9600) ? 9600 : len;
    W = (L + 7) / 8;
    for (int p = 0; p < n; p++) begin
      for (int w = 0; w < W; w++) begin
        x.d = '0;
        for (int j = 0; j < 8; j++) x.d[63-8*j -: 8] = 8'((sd + p + 8*w + j) % 256);
        x.sop = (w == 0);
        x.eop = (w == W - 1);
        x.mod = (w == W - 1) ? 3'(L % 8) : 3'd0;
        exp_q.push_back(x);
      end
    end
  endtask

  task automatic clear_mon();
    word_cnt = 0; sop_cnt = 0; eop_cnt = 0; stall_cnt = 0; done_cnt = 0;
    first_sop_cyc = -1; last_eop_cyc = -1; done_cyc = -1; pkts_at_done = -1;
    in_frame = 0; last_mod = '0;
    sop_data.delete(); gaps.delete();
  endtask

  always @(posedge clk_156m25) begin
    cyc       <= cyc + 1;
    full_prev <= pkt_tx_full;
  end

  always @(negedge clk_156m25) begin
    if (chk_en) begin
      if (pkt_tx_val) begin
        chk("val_after_full", {63'd0, full_prev}, 64'd0);
        if (exp_q.size() == 0) chk("extra_word", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("data", pkt_tx_data, e.d);
          chk("sop", {63'd0, pkt_tx_sop}, {63'd0, e.sop});
          chk("eop", {63'd0, pkt_tx_eop}, {63'd0, e.eop});
          chk("mod", {61'd0, pkt_tx_mod}, {61'd0, e.mod});
        end
        word_cnt++;
        if (pkt_tx_sop) begin
          if (sop_cnt == 0) first_sop_cyc = cyc;
          else gaps.push_back(cyc - last_eop_cyc - 1);
          sop_cnt++;
          sop_data.push_back(pkt_tx_data);
          in_frame = 1;
        end
        if (pkt_tx_eop) begin
          eop_cnt++; last_eop_cyc = cyc; last_mod = pkt_tx_mod; in_frame = 0;
        end
      end else begin
        chk("idle_zero", pkt_tx_data | {59'd0, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}, 64'd0);
        if (in_frame) stall_cnt++;
      end
      if (done) begin
        done_cnt++; done_cyc = cyc; pkts_at_done = int'(pkts_sent);
      end
    end
  end

  task automatic do_start(input int n, input int len, input int sd, input int model_frames);
    push_run(model_frames, len, sd);
    @(posedge clk_156m25); #1;
    num_pkts = 16'(n); pkt_len = 16'(len); seed = 8'(sd); start = 1'b1; start_cyc = cyc;
    @(posedge clk_156m25); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < maxc && done_cnt == d0; i++) begin @(negedge clk_156m25); #1; end
    if (done_cnt == d0) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_words(input int n);
    for (int i = 0; i < 200 && word_cnt < n; i++) begin @(negedge clk_156m25); #1; end
    if (word_cnt < n) chk("word_timeout", 64'(word_cnt), 64'(n));
  endtask

  task automatic wait_sops(input int n);
    for (int i = 0; i < 400 && sop_cnt < n; i++) begin @(negedge clk_156m25); #1; end
    if (sop_cnt < n) chk("sop_timeout", 64'(sop_cnt), 64'(n));
  endtask

  int t2_len[3]   = '{61, 0, 20000};
  int t2_words[3] = '{8, 1, 1200};
  int t2_mod[3]   = '{5, 1, 0};

  initial begin
    clear_mon();
    repeat (3) @(posedge clk_156m25);
    @(negedge clk_156m25); #1;
    chk("rst_outputs", {pkt_tx_data[0], pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done}, 64'd0);
    chk("rst_data", pkt_tx_data, 64'd0);
    chk("rst_pkts_sent", 64'(pkts_sent), 64'd0);
    reset_156m25_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk_156m25); #1;
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // single 64-byte frame
    clear_mon();
    do_start(1, 64, 'h10, 1);
    wait_done(60);
    chk("t1_sop_latency", 64'(first_sop_cyc), 64'(start_cyc + 2));
    if (sop_data.size() > 0) chk("t1_first_word", sop_data[0], 64'h1011121314151617);
    chk("t1_words", 64'(word_cnt), 64'd8);
    chk("t1_mod", {61'd0, last_mod}, 64'd0);
    chk("t1_done_after_eop", 64'(done_cyc), 64'(last_eop_cyc + 1));
    chk("t1_pkts_sent", 64'(pkts_at_done), 64'd1);
    chk("t1_busy_low", {63'd0, busy}, 64'd0);
    chk("t1_model_empty", 64'(exp_q.size()), 64'd0);

    // length rounding and clamping
    for (int t = 0; t < 3; t++) begin
      clear_mon();
      do_start(1, t2_len[t], 'h33, 1);
      wait_done(1300);
      chk("t2_words", 64'(word_cnt), 64'(t2_words[t]));
      chk("t2_mod", {61'd0, last_mod}, 64'(t2_mod[t]));
      chk("t2_model_empty", 64'(exp_q.size()), 64'd0);
    end

    // backpressure on word 3 for five cycles
    clear_mon();
    do_start(1, 64, 'h5A, 1);
    wait_words(3);
    pkt_tx_full = 1'b1;
    repeat (5) @(negedge clk_156m25);
    #1 pkt_tx_full = 1'b0;
    wait_done(60);
    chk("t3_stall_cycles", 64'(stall_cnt), 64'd5);
    chk("t3_words", 64'(word_cnt), 64'd8);
    chk("t3_model_empty", 64'(exp_q.size()), 64'd0);

    // three frames with inter-frame gap; a start during the run is ignored
    clear_mon();
    do_start(3, 24, 'h40, 3);
    @(posedge clk_156m25); #1;
    num_pkts = 16'd9; pkt_len = 16'd100; seed = 8'h00; start = 1'b1;
    @(posedge clk_156m25); #1;
    start = 1'b0;
    wait_done(100);
    chk("t4_gap_count", 64'(gaps.size()), 64'd2);
    if (gaps.size() == 2) begin
      chk("t4_gap0", 64'(gaps[0]), 64'd2);
      chk("t4_gap1", 64'(gaps[1]), 64'd2);
    end
    if (sop_data.size() > 1) chk("t4_frame1_byte0", {56'd0, sop_data[1][63:56]}, 64'h41);
    chk("t4_pkts_sent", 64'(pkts_at_done), 64'd3);
    chk("t4_words", 64'(word_cnt), 64'd9);
    chk("t4_model_empty", 64'(exp_q.size()), 64'd0);

    // continuous run aborted in the middle of the fourth frame
    clear_mon();
    do_start(0, 32, 'h80, 4);
    wait_sops(4);
    abort = 1'b1;
    @(posedge clk_156m25); #1;
    abort = 1'b0;
    wait_done(100);
    chk("t5_pkts_sent", 64'(pkts_at_done), 64'd4);
    chk("t5_model_empty", 64'(exp_q.size()), 64'd0);
    repeat (20) @(negedge clk_156m25);
    #1;
    chk("t5_no_more_words", 64'(word_cnt), 64'd16);
    chk("t5_eops", 64'(eop_cnt), 64'd4);
    chk("t5_done_once", 64'(done_cnt), 64'd1);
    chk("t5_busy_low", {63'd0, busy}, 64'd0);

    // reset in the middle of a frame, then a clean run
    clear_mon();
    do_start(1, 64, 'h11, 1);
    wait_sops(1);
    chk_en = 1'b0;
    #2 reset_156m25_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", {57'd0, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done}, 64'd0);
    chk("t6_rst_data", pkt_tx_data, 64'd0);
    chk("t6_rst_pkts", 64'(pkts_sent), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_156m25);
    @(negedge clk_156m25); #1;
    reset_156m25_n = 1'b1;
    chk_en = 1'b1;
    clear_mon();
    do_start(1, 16, 'h22, 1);
    wait_done(40);
    chk("t6_sop_latency", 64'(first_sop_cyc), 64'(start_cyc + 2));
    if (sop_data.size() > 0) chk("t6_first_word", sop_data[0], 64'h2223242526272829);
    chk("t6_words", 64'(word_cnt), 64'd2);
    chk("t6_model_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
